// File: rtl/call_stack_param_pkg.sv
// Shared definitions for the hardware return-address stack: command
// encodings (also used by the control unit) and overflow policy codes.
package call_stack_param_pkg;

  localparam int STACK_CMD_WIDTH = 2;

  typedef enum logic [STACK_CMD_WIDTH-1:0] {
    STACK_NOP     = 2'b00,
    STACK_PUSH    = 2'b01,
    STACK_POP     = 2'b10,
    STACK_REPLACE = 2'b11
  } stack_cmd_e;

  // Overflow/underflow policy selected by the OVF_MODE parameter.
  localparam int STACK_OVF_SHIFT = 0;  // push on full drops oldest, pop duplicates bottom
  localparam int STACK_OVF_SAT   = 1;  // push on full / pop on empty leave storage alone

endpackage

// File: rtl/call_stack_param.sv
// Parametrised return-address stack. Entry 0 is the top of stack and is
// presented combinationally on top_out. One command is accepted per cycle;
// its effect is visible right after the sampling edge.
module call_stack_param
  import call_stack_param_pkg::*;
#(
  parameter  int PC_WIDTH = 11,
  parameter  int DEPTH    = 2,
  parameter  int OVF_MODE = STACK_OVF_SHIFT,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STACK_CMD_WIDTH-1:0] cmd_in,
  input  logic [PC_WIDTH-1:0]        push_data,
  input  logic                       clear_flags,
  output logic [PC_WIDTH-1:0]        top_out,
  output logic [CW-1:0]              depth_out,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  logic [PC_WIDTH-1:0] entry     [DEPTH];
  logic [PC_WIDTH-1:0] entry_nxt [DEPTH];
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                ovf_evt;
  logic                unf_evt;
  logic                ovf_q;
  logic                unf_q;
  logic                is_full;
  logic                is_empty;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);

  // Next storage contents, occupancy and error events for the current command.
  always_comb begin
    entry_nxt = entry;
    cnt_nxt   = cnt;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    case (cmd_in)
      STACK_PUSH: begin
        ovf_evt = is_full;
        // In shift mode a push on full still shifts, losing the bottom entry.
        if (!is_full || OVF_MODE == STACK_OVF_SHIFT) begin
          for (int i = DEPTH - 1; i > 0; i--) begin
            entry_nxt[i] = entry[i-1];
          end
          entry_nxt[0] = push_data;
        end
        if (!is_full) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STACK_POP: begin
        unf_evt = is_empty;
        // Shift mode pops even when empty, which keeps duplicating the bottom.
        if (!is_empty || OVF_MODE == STACK_OVF_SHIFT) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            entry_nxt[i] = entry[i+1];
          end
          if (OVF_MODE == STACK_OVF_SAT) begin
            entry_nxt[DEPTH-1] = '0;
          end
        end
        if (!is_empty) begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STACK_REPLACE: begin
        entry_nxt[0] = push_data;
        if (is_empty) begin
          cnt_nxt = CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Storage, occupancy and sticky flags; a new error event beats clear_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      entry <= entry_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_evt | (ovf_q & ~clear_flags);
      unf_q <= unf_evt | (unf_q & ~clear_flags);
    end
  end

  assign top_out   = entry[0];
  assign depth_out = cnt;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/call_stack_param.md
Name: call_stack_param

Overview:
- Parametrised hardware return-address stack for the PIC16C5x-family core; the successor to the fixed 2-level call stack.
- Sits beside the PC block. Driven by the 2-bit stack command from the control unit; supplies the return address on top_out.
- Adds configurable depth and width, an overflow policy, a combined pop+push (replace) command, and occupancy/status flags with sticky error bits.

Parameters:
- PC_WIDTH, 11, width of each stored address.
- DEPTH, 2, number of entries; legal range 2..16.
- OVF_MODE, 0, overflow/underflow policy. 0 = legacy shift: push on full drops the oldest entry; pop duplicates the bottom entry. 1 = saturate: push on full is ignored; pop on empty leaves contents unchanged.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_in  in  2  stack command: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE (pop then push in one cycle).
- push_data  in  PC_WIDTH  address to store on PUSH/REPLACE.
- clear_flags  in  1  clears the sticky overflow and underflow bits.
- top_out  out  PC_WIDTH  current top entry (entry 0), combinational from registers.
- depth_out  out  CW  occupancy 0..DEPTH, where CW = $clog2(DEPTH+1).
- full  out  1  depth_out == DEPTH.
- empty  out  1  depth_out == 0.
- overflow  out  1  sticky: a PUSH was issued while full.
- underflow  out  1  sticky: a POP was issued while empty.

Behaviour:
- Storage: entries e[0..DEPTH-1]; e[0] is the top. Counter cnt holds occupancy.
- Reset (rst=1 at edge): all entries 0, cnt=0, overflow=0, underflow=0. Therefore top_out=0, depth_out=0, empty=1, full=0. rst takes priority over every command and over clear_flags.
- Latency: a command sampled at edge N is visible on top_out/depth_out/flags after edge N. There is no stall and no handshake; a command is accepted every cycle.
- PUSH, not full: e[i+1]<=e[i] for all i, e[0]<=push_data, cnt+1.
- PUSH, full:
  - OVF_MODE 0: same shift (e[DEPTH-1] is lost), cnt unchanged.
  - OVF_MODE 1: no change to storage.
  - Both modes: overflow<=1.
- POP, not empty: e[i]<=e[i+1] for i<DEPTH-1, cnt-1.
  - OVF_MODE 0: e[DEPTH-1] keeps its value (bottom duplicated).
  - OVF_MODE 1: e[DEPTH-1]<=0.
- POP, empty:
  - OVF_MODE 0: shift as above, cnt stays 0.
  - OVF_MODE 1: no change.
  - Both modes: underflow<=1.
- REPLACE: e[0]<=push_data and no other entry moves. cnt unchanged if nonzero; cnt becomes 1 if it was 0. No flag is set.
- clear_flags: same cycle as an error event -> the event wins and the flag ends 1. Otherwise both sticky bits go to 0.
- cnt never wraps: it is saturated at 0 and DEPTH in all modes.
- Sticky bits hold until rst or clear_flags.
- Values on cmd_in when not NOP are interpreted every cycle; the caller must drive NOP when idle.

Decomposition:
- Shared package (define file):
  - STACK_CMD_WIDTH = 2.
  - Command encodings STACK_NOP / STACK_PUSH / STACK_POP / STACK_REPLACE, shared with ControlUnit.
  - OVF_MODE encodings STACK_OVF_SHIFT = 0 and STACK_OVF_SAT = 1.
- Single module: the shift array, counter and flag logic are tightly coupled, so no sub-module is warranted.

Test Plan:
- Reset then idle: rst=1 one cycle, then NOP -> top_out=0, depth_out=0, empty=1, full=0, overflow=0, underflow=0.
- DEPTH=2, OVF_MODE=0: PUSH 0x123, PUSH 0x456, PUSH 0x789 -> top_out 0x789, e[1]=0x456, depth_out=2, full=1, overflow=1. Then POP,POP,POP -> top_out 0x456, then 0x456, then 0x456, depth_out=0, underflow=1.
- DEPTH=4, OVF_MODE=1: push 1,2,3,4,5 -> 5 ignored, top_out=4, overflow=1. Pop x5 -> top_out sequence 3,2,1,0,0, empty=1, underflow=1.
- REPLACE: empty stack, REPLACE 0x0AA -> top_out=0x0AA, depth_out=1. PUSH 0x0BB then REPLACE 0x0CC -> top 0x0CC, e[1]=0x0AA, depth_out=2, no flag set.
- Flag priority: full stack, PUSH with clear_flags=1 in the same cycle -> overflow=1. Next cycle clear_flags=1 with NOP -> overflow=0.
- Mid-operation reset: depth_out=3, assert rst together with PUSH 0x7FF -> next cycle top_out=0, depth_out=0, flags 0.
